audio_led_pwm: RTL and testbench

Parametrised, multi-channel successor to the single-channel audio LED driver. Takes NCH offset-binary audio samples from the XADC front end, tracks a per-channel peak envelope with timed decay, maps envelopes to duty cycles according to a 3-bit display mode, and drives NCH glitch-free PWM outputs. It sits between the XADC sampling block and the LED cube pins in the top level.

---
 rtl/audio_led_pkg.sv | 18 +
 rtl/env_follower.sv | 59 +++++
 rtl/audio_led_pwm.sv | 125 ++++++++++++
 tb/tb_audio_led_pwm.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/audio_led_pkg.sv
// Shared display-mode encoding and sample-format helpers for the audio LED PWM driver.
package audio_led_pkg;

  typedef enum logic [2:0] {
    MODE_OFF    = 3'd0,
    MODE_ON     = 3'd1,
    MODE_ENV    = 3'd2,
    MODE_BAR    = 3'd3,
    MODE_BREATH = 3'd4,
    MODE_SQ     = 3'd5
  } mode_e;

  // Offset-binary zero point for a sample of width sw.
  function automatic logic [31:0] midscale(input int sw);
    return 32'd1 << (sw - 1);
  endfunction

endpackage

// File: rtl/env_follower.sv
// One audio channel: offset-binary magnitude stage followed by a peak envelope
// with instant attack and tick-timed proportional decay.
module env_follower
  import audio_led_pkg::*;
#(
  parameter int SW          = 16,
  parameter int PW          = 8,
  parameter int DECAY_SHIFT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_valid,
  input  logic [SW-1:0] sample,
  input  logic          tick,
  output logic [PW-1:0] env
);

  localparam logic [SW-1:0] MID  = SW'(midscale(SW));
  localparam logic [SW-1:0] MAXM = MID - 1'b1;

  logic [SW-1:0] diff;
  logic [SW-1:0] m;
  logic [PW-1:0] mag_next;
  logic [PW-1:0] mag_q;
  logic          mag_vld;
  logic [PW-1:0] step;
  logic [PW-1:0] decayed;
  logic          attack;

  // A full-scale negative sample (distance 2^(SW-1)) is clipped so it maps to
  // the top magnitude code instead of wrapping to zero.
  always_comb begin
    diff     = (sample >= MID) ? (sample - MID) : (MID - sample);
    m        = (diff > MAXM) ? MAXM : diff;
    mag_next = PW'(m >> (SW - 1 - PW));
  end

  always_comb begin
    step    = env >> DECAY_SHIFT;
    if (step == '0) step = PW'(1);
    decayed = (env == '0) ? '0 : (env - step);
    attack  = mag_vld && (mag_q > env);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q   <= '0;
      mag_vld <= 1'b0;
      env     <= '0;
    end else begin
      mag_vld <= sample_valid;
      if (sample_valid) mag_q <= mag_next;
      // Attack has priority over a coincident decay tick.
      if (attack)    env <= mag_q;
      else if (tick) env <= decayed;
    end
  end

endmodule

// File: rtl/audio_led_pwm.sv
// Multi-channel audio-reactive LED PWM: per-channel envelopes, mode-selected
// duty mux, and period-aligned duty latching for glitch-free outputs.
module audio_led_pwm
  import audio_led_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SW          = 16,
  parameter int PW          = 8,
  parameter int DECAY_SHIFT = 4,
  parameter int TICK_DIV    = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [NCH*SW-1:0] sample,
  input  logic [2:0]        mode,
  output logic [NCH-1:0]    pwm,
  output logic [NCH*PW-1:0] env
);

  // sample_valid is a one-cycle strobe with no ready: every strobe is consumed
  // for all channels at once, back-to-back strobes included.

  localparam int            TW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam int            BAR_STEP = (1 << PW) / NCH;
  localparam logic [PW:0]   FULL     = (PW+1)'(1 << PW);

  logic [TW-1:0]              tick_cnt;
  logic                       tick;
  logic [PW-1:0]              breath;
  logic                       breath_up;
  logic [PW-1:0]              cnt;
  logic [PW-1:0]              cnt_n;
  logic                       wrap;
  logic [NCH-1:0][PW-1:0]     env_ch;
  logic [NCH-1:0][PW:0]       duty;
  logic [NCH-1:0][PW:0]       duty_lat;
  logic [NCH-1:0]             pwm_n;

  assign tick  = (tick_cnt == TICK_MAX);
  assign wrap  = (cnt == '1);
  assign cnt_n = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt  <= '0;
      breath    <= '0;
      breath_up <= 1'b1;
    end else begin
      tick_cnt <= tick ? '0 : (tick_cnt + 1'b1);
      // Triangle ramp: each endpoint value is shown for a single tick.
      if (tick) begin
        if (breath_up) begin
          if (breath == '1) begin
            breath_up <= 1'b0;
            breath    <= breath - 1'b1;
          end else begin
            breath <= breath + 1'b1;
          end
        end else begin
          if (breath == '0) begin
            breath_up <= 1'b1;
            breath    <= breath + 1'b1;
          end else begin
            breath <= breath - 1'b1;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [PW:0] BAR_THR = (PW+1)'(i * BAR_STEP);

    logic [PW:0]     duty_c;
    logic [2*PW-1:0] sq;

    env_follower #(
      .SW          (SW),
      .PW          (PW),
      .DECAY_SHIFT (DECAY_SHIFT)
    ) u_env (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .sample       (sample[i*SW +: SW]),
      .tick         (tick),
      .env          (env_ch[i])
    );

    always_comb begin
      sq     = {{PW{1'b0}}, env_ch[i]} * {{PW{1'b0}}, env_ch[i]};
      duty_c = '0;
      case (mode_e'(mode))
        MODE_OFF:    duty_c = '0;
        MODE_ON:     duty_c = FULL;
        MODE_ENV:    duty_c = {1'b0, env_ch[i]};
        MODE_BAR:    duty_c = ({1'b0, env_ch[0]} > BAR_THR) ? FULL : '0;
        MODE_BREATH: duty_c = {1'b0, breath};
        MODE_SQ:     duty_c = (PW+1)'(sq >> PW);
        default:     duty_c = '0;
      endcase
    end

    assign duty[i]            = duty_c;
    assign env[i*PW +: PW]    = env_ch[i];
    assign pwm_n[i]           = {1'b0, cnt_n} < (wrap ? duty_c : duty_lat[i]);
  end

  // Outputs are registered against the next counter value so pwm lines up
  // with cnt and a new duty only takes effect at the start of a period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      duty_lat <= '0;
      pwm      <= '0;
    end else begin
      cnt <= cnt_n;
      pwm <= pwm_n;
      if (wrap) duty_lat <= duty;
    end
  end

endmodule

// File: tb/tb_audio_led_pwm.sv
// Directed bench for audio_led_pwm: envelope timing, decay, modes, breath ramp,
// period-aligned duty changes and mid-period reset.
module tb_audio_led_pwm;

  localparam int NCH = 4;
  localparam int SW  = 16;
  localparam int PW  = 8;
  localparam logic [NCH*SW-1:0] MID_ALL = {NCH{16'h8000}};

  logic              clk = 1'b0;
  logic              rst;
  logic              sample_valid;
  logic [NCH*SW-1:0] sample;
  logic [2:0]        mode;
  logic [NCH-1:0]    pwm;
  logic [NCH*PW-1:0] env;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hc[NCH];
  logic [31:0] exp_q[$];

  audio_led_pwm #(
    .NCH         (NCH),
    .SW          (SW),
    .PW          (PW),
    .DECAY_SHIFT (4),
    .TICK_DIV    (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .mode         (mode),
    .pwm          (pwm),
    .env          (env)
  );

  // Clock and edge index since reset release (edge k leaves cnt = k mod 256).
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // High-cycle count per channel within the current 256-cycle period.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NCH; i++) begin
      if (cyc % 256 == 0) hc[i] = int'(pwm[i]);
      else                hc[i] = hc[i] + int'(pwm[i]);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < n) check_eq("wait_bound", cyc, n);
  endtask

  task automatic strobe_at(input int k, input logic [NCH*SW-1:0] s);
    wait_cyc(k - 1);
    sample_valid = 1'b1;
    sample       = s;
    wait_cyc(k);
    sample_valid = 1'b0;
    sample       = MID_ALL;
  endtask

  task automatic check_period(input string tag, input int e0, input int e1, input int e2, input int e3);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    exp_q.push_back(e3);
    for (int i = 0; i < NCH; i++)
      check_eq($sformatf("%s_ch%0d", tag, i), hc[i], exp_q.pop_front());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sample_valid = 1'b0;
    sample = MID_ALL;
    mode = 3'd2;
    repeat (3) @(negedge clk);
    check_eq("reset_pwm", pwm, 0);
    check_eq("reset_env", env, 0);
    rst = 1'b0;

    // Full-scale positive sample on ch0; env appears two edges after strobe.
    strobe_at(1, {16'h8000, 16'h8000, 16'h8000, 16'hFFFF});
    check_eq("env_lat1", env, 0);
    wait_cyc(2);   check_eq("env_attack_ffff", env, 32'h0000_00FF);
    wait_cyc(16);  check_eq("decay_t1", env, 32'h0000_00F0);
    wait_cyc(31);  check_eq("decay_hold", env, 32'h0000_00F0);
    wait_cyc(32);  check_eq("decay_t2", env, 32'h0000_00E1);

    // Mixed magnitudes, including a clipped full-scale negative on ch2.
    strobe_at(253, {16'h8000, 16'h0000, 16'h4000, 16'hBFFF});
    wait_cyc(254); check_eq("env_multi", env, 32'h00FF_807F);
    wait_cyc(255); check_eq("env_multi_hold", env, 32'h00FF_807F);
    wait_cyc(256); check_eq("decay_7f_t1", env, 32'h00F0_7878);
    wait_cyc(272); check_eq("decay_7f_t2", env, 32'h00E1_7171);

    wait_cyc(300); mode = 3'd3;
    strobe_at(509, {16'h8000, 16'h8000, 16'h8000, 16'hA800});
    wait_cyc(510); check_eq("env0_bar", env[7:0], 8'h50);
    // ch3 attack lands on the same edge as a decay tick.
    strobe_at(511, {16'h5800, 16'h8000, 16'h8000, 16'h8000});
    check_period("p_env", 127, 128, 255, 0);
    wait_cyc(512);
    check_eq("attack_on_tick", env[31:24], 8'h50);
    check_eq("decay_on_tick_ch0", env[7:0], 8'h4B);
    wait_cyc(528); check_eq("attack_then_decay", env[31:24], 8'h4B);

    wait_cyc(600); mode = 3'd2;
    strobe_at(765, {16'h4800, 16'hF000, 16'hD000, 16'hB000});
    wait_cyc(766); check_eq("env_set3", env, 32'h70E0_A060);
    wait_cyc(767); check_period("p_bar", 256, 256, 0, 0);

    // Mid-period switch to full-on must not disturb the running period.
    wait_cyc(816);  mode = 3'd1;
    wait_cyc(1023); check_period("p_switch", 96, 160, 224, 112);
    wait_cyc(1100); mode = 3'd0;
    wait_cyc(1279); check_period("p_on", 256, 256, 256, 256);

    wait_cyc(1300); mode = 3'd5;
    strobe_at(1533, {16'h2000, 16'hA000, 16'hC000, 16'hFFFF});
    wait_cyc(1534); check_eq("env_set_sq", env, 32'hC040_80FF);
    wait_cyc(1535); check_period("p_off", 0, 0, 0, 0);
    wait_cyc(1700); mode = 3'd4;
    wait_cyc(1791); check_period("p_sq", 254, 64, 16, 144);
    wait_cyc(2047); check_period("p_breath_111", 111, 111, 111, 111);

    wait_cyc(4000); check_eq("env_decayed_zero", env, 0);
    strobe_at(4030, {16'h8000, 16'h8000, 16'h8000, 16'h8280});
    wait_cyc(4031); check_eq("env_small", env, 32'h5);
    wait_cyc(4032); check_eq("decay_min_step", env, 32'h4);
    wait_cyc(4080); check_eq("decay_to_1", env, 32'h1);
    wait_cyc(4095); check_period("p_breath_239", 239, 239, 239, 239);
    wait_cyc(4096); check_eq("decay_to_0", env, 0);
    wait_cyc(4112); check_eq("zero_stays", env, 0);
    wait_cyc(4351); check_period("p_breath_top", 255, 255, 255, 255);
    wait_cyc(4607); check_period("p_breath_down", 239, 239, 239, 239);
    wait_cyc(8447); check_period("p_breath_bottom", 1, 1, 1, 1);
    wait_cyc(8703); check_period("p_breath_up", 17, 17, 17, 17);

    // Reset in the middle of a full-on period.
    mode = 3'd1;
    strobe_at(8800, {16'h8000, 16'h0000, 16'h8000, 16'h8000});
    wait_cyc(8900);
    check_eq("pre_reset_pwm", pwm, 4'hF);
    check_eq("pre_reset_env2", env[23:16], 8'hAF);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midreset_pwm", pwm, 0);
    check_eq("midreset_env", env, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_cyc(1);   check_eq("post_reset_pwm1", pwm, 0);
    wait_cyc(255); check_eq("post_reset_pwm255", pwm, 0);
    wait_cyc(256); check_eq("post_reset_pwm256", pwm, 4'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
